// File: rtl/gb_frame_capture.sv
// Packs the lcd 2-bit pixel stream four pixels per byte into a linear framebuffer,
// emitting byte writes through a first-word-fall-through FIFO with a valid/ready port.
module gb_frame_capture #(
  parameter int unsigned LCD_WIDTH  = 160,
  parameter int unsigned LCD_HEIGHT = 144,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              capture_en,
  input  logic [1:0]        px_color,
  input  logic              px_valid,
  input  logic [7:0]        px_x,
  input  logic [7:0]        px_y,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overflow,
  output logic              sync_error,
  output logic              busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_SOF,
    CAPTURE,
    DRAIN
  } state_t;

  state_t            state;
  logic [7:0]        ex;
  logic [7:0]        ey;
  logic [5:0]        pack;
  logic [ADDR_W-1:0] byte_addr;

  logic [ADDR_W+7:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic sof;
  logic px_match;
  logic last_px;
  logic push_req;
  logic push_ok;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    pop        = !fifo_empty && fb_wr_ready;
    sof        = px_valid && capture_en && (px_x == 8'd0) && (px_y == 8'd0);
    // ex/ey never leave the frame, so out-of-range coordinates fail this compare
    px_match   = (px_x == ex) && (px_y == ey);
    last_px    = (px_x == 8'(LCD_WIDTH-1)) && (px_y == 8'(LCD_HEIGHT-1));
    push_req   = (state == CAPTURE) && px_valid && px_match && (px_x[1:0] == 2'd3);
    push_ok    = push_req && (!fifo_full || pop);
  end

  assign fb_wr_valid = !fifo_empty;
  assign {fb_wr_addr, fb_wr_data} = fifo_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= {byte_addr, px_color, pack};
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= WAIT_SOF;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      sync_error  <= 1'b0;
      ex          <= '0;
      ey          <= '0;
      pack        <= '0;
      byte_addr   <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        WAIT_SOF: begin
          if (sof) begin
            overflow   <= 1'b0;
            sync_error <= 1'b0;
            pack       <= {4'b0, px_color};
            ex         <= 8'd1;
            ey         <= 8'd0;
            byte_addr  <= '0;
            state      <= CAPTURE;
            busy       <= 1'b1;
          end
        end
        CAPTURE: begin
          if (px_valid) begin
            if (px_match) begin
              case (px_x[1:0])
                2'd0: pack[1:0] <= px_color;
                2'd1: pack[3:2] <= px_color;
                2'd2: pack[5:4] <= px_color;
                default: begin
                  // address advances even when the byte is dropped
                  byte_addr <= byte_addr + ADDR_W'(1);
                  if (!push_ok) overflow <= 1'b1;
                end
              endcase
              if (px_x == 8'(LCD_WIDTH-1)) begin
                ex <= '0;
                ey <= ey + 8'd1;
              end else begin
                ex <= ex + 8'd1;
              end
              if (last_px) state <= DRAIN;
            end else begin
              sync_error <= 1'b1;
              pack       <= '0;
              state      <= WAIT_SOF;
              busy       <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            state       <= WAIT_SOF;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_SOF;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_frame_capture.sv
// Directed bench for gb_frame_capture on a reduced 16x8 frame; a FIFO model
// scoreboard predicts every framebuffer write and any dropped byte.
module tb_gb_frame_capture;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 8;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 6;

  logic          clock = 1'b0;
  logic          nreset;
  logic          capture_en;
  logic [1:0]    px_color;
  logic          px_valid;
  logic [7:0]    px_x;
  logic [7:0]    px_y;
  logic          fb_wr_valid;
  logic          fb_wr_ready;
  logic [AW-1:0] fb_wr_addr;
  logic [7:0]    fb_wr_data;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          overflow;
  logic          sync_error;
  logic          busy;

  always #5 clock = ~clock;

  gb_frame_capture #(
    .LCD_WIDTH (W),
    .LCD_HEIGHT(H),
    .FIFO_DEPTH(D),
    .ADDR_W    (AW)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .capture_en (capture_en),
    .px_color   (px_color),
    .px_valid   (px_valid),
    .px_x       (px_x),
    .px_y       (px_y),
    .fb_wr_valid(fb_wr_valid),
    .fb_wr_ready(fb_wr_ready),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .overflow   (overflow),
    .sync_error (sync_error),
    .busy       (busy)
  );

  int            tests = 0;
  int            fails = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            exp_fc = 0;
  int            w0, d0;
  logic [AW+7:0] model_q[$];
  bit            exp_push = 1'b0;
  logic [AW+7:0] exp_word;
  logic [7:0]    pk = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: evaluates what the next rising edge does, with inputs already stable.
  always @(negedge clock) begin
    bit pop;
    pop = (model_q.size() > 0) && fb_wr_ready;
    chk("wr_valid", fb_wr_valid, (model_q.size() > 0));
    if (pop) begin
      chk("wr_addr", fb_wr_addr, model_q[0][AW+7:8]);
      chk("wr_data", fb_wr_data, model_q[0][7:0]);
    end
    if (exp_push && (model_q.size() < D || pop)) model_q.push_back(exp_word);
    if (pop) begin
      void'(model_q.pop_front());
      wr_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic px(input int x, input int y, input logic [1:0] c, input bit push);
    pk[2*(x%4) +: 2] = c;
    px_valid = 1'b1;
    px_x     = 8'(x);
    px_y     = 8'(y);
    px_color = c;
    exp_push = push;
    exp_word = {AW'(y*(W/4) + x/4), pk};
    @(posedge clock);
    #1;
    px_valid = 1'b0;
    exp_push = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input bit en, input int skip_x, input int skip_y,
                            input int en_off_y, input int stop_x, input int stop_y);
    bit live;
    logic [1:0] c;
    live = en;
    capture_en = en;
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        if (x == stop_x && y == stop_y) return;
        if (x == skip_x && y == skip_y) begin
          live = 1'b0;
          continue;
        end
        if (y >= en_off_y) capture_en = 1'b0;
        c = rnd ? 2'($urandom_range(3)) : 2'(x % 4);
        px(x, y, c, live && (x % 4 == 3));
        if (live && x == 0 && y == 0) begin
          chk("sof_ovf_clear", overflow, 0);
          chk("sof_sync_clear", sync_error, 0);
          chk("sof_busy", busy, 1);
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || fb_wr_valid) && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle_timeout", (n < bound), 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset      = 1'b0;
    capture_en  = 1'b0;
    px_valid    = 1'b0;
    px_color    = '0;
    px_x        = '0;
    px_y        = '0;
    fb_wr_ready = 1'b1;
    #1;
    chk("rst_valid", fb_wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sync", sync_error, 0);
    repeat (2) @(posedge clock);
    #1;
    nreset = 1'b1;

    // full frame, colour x%4, always ready: every byte 8'hE4, addresses in order
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(0, 1, -1, -1, H + 1, -1, -1);
    wait_idle(200);
    chk("t1_writes", wr_cnt - w0, 32);
    chk("t1_done", done_cnt - d0, 1);
    exp_fc++;
    chk("t1_fc", frame_count, exp_fc);
    chk("t1_ovf", overflow, 0);
    chk("t1_sync", sync_error, 0);

    // sink stalled for 50 cycles: bytes 8..11 dropped
    w0 = wr_cnt; d0 = done_cnt;
    fork
      send_frame(1, 1, -1, -1, H + 1, -1, -1);
      begin
        fb_wr_ready = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        fb_wr_ready = 1'b1;
      end
    join
    wait_idle(200);
    chk("t2_writes", wr_cnt - w0, 28);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_ovf", overflow, 1);
    exp_fc++;
    chk("t2_fc", frame_count, exp_fc);

    // line 0 skips x=5: abort, then a clean frame clears the flag at SOF
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(1, 1, 5, 0, H + 1, -1, -1);
    chk("t3_sync", sync_error, 1);
    chk("t3_busy", busy, 0);
    wait_idle(200);
    chk("t3_writes", wr_cnt - w0, 1);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_fc_hold", frame_count, exp_fc);
    send_frame(1, 1, -1, -1, H + 1, -1, -1);
    wait_idle(200);
    exp_fc++;
    chk("t3_fc", frame_count, exp_fc);
    chk("t3_sync_after", sync_error, 0);

    // capture disabled at SOF, then disabled mid-frame after a good SOF
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(1, 0, -1, -1, H + 1, -1, -1);
    chk("t4_busy", busy, 0);
    wait_idle(50);
    chk("t4_nowrite", wr_cnt - w0, 0);
    chk("t4_nodone", done_cnt - d0, 0);
    send_frame(1, 1, -1, -1, 3, -1, -1);
    wait_idle(200);
    exp_fc++;
    chk("t4_fc", frame_count, exp_fc);
    chk("t4_writes", wr_cnt - w0, 32);

    // FIFO full when ready returns on the same cycle as a push: no drop
    w0 = wr_cnt;
    fork
      send_frame(1, 1, -1, -1, H + 1, -1, -1);
      begin
        fb_wr_ready = 1'b0;
        repeat (35) @(posedge clock);
        #1;
        fb_wr_ready = 1'b1;
      end
    join
    wait_idle(200);
    chk("t5_ovf", overflow, 0);
    chk("t5_writes", wr_cnt - w0, 32);
    exp_fc++;
    chk("t5_fc", frame_count, exp_fc);

    // async reset with three bytes queued at line 5
    fork
      send_frame(1, 1, -1, -1, H + 1, 12, 5);
      begin
        repeat (81) @(posedge clock);
        #1;
        fb_wr_ready = 1'b0;
      end
    join
    chk("t6_queued", fb_wr_valid, 1);
    #2;
    nreset = 1'b0;
    model_q.delete();
    #1;
    chk("t6_valid", fb_wr_valid, 0);
    chk("t6_addr", fb_wr_addr, 0);
    chk("t6_data", fb_wr_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fc", frame_count, 0);
    exp_fc = 0;
    repeat (2) @(posedge clock);
    #1;
    nreset = 1'b1;
    fb_wr_ready = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    capture_en = 1'b1;
    for (int x = 12; x < int'(W); x++) px(x, 5, 2'(x % 4), 1'b0);
    for (int y = 6; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++) px(x, y, 2'(x % 4), 1'b0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_nowrite", wr_cnt - w0, 0);
    send_frame(1, 1, -1, -1, H + 1, -1, -1);
    wait_idle(200);
    exp_fc++;
    chk("t6_fc_after", frame_count, exp_fc);
    chk("t6_done", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
